// File: rtl/run_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_sequencer_if                                                     |
// | Preload stream, data-memory side-port and dump stream bundle.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface run_sequencer_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;

   modport master (
      input  in_valid, in_addr, in_data, in_last, mem_rdata, out_ready,
      output in_ready, mem_we, mem_addr, mem_wdata, out_valid, out_addr, out_data
   );

   modport slave (
      output in_valid, in_addr, in_data, in_last, mem_rdata, out_ready,
      input  in_ready, mem_we, mem_addr, mem_wdata, out_valid, out_addr, out_data
   );
endinterface
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_sequencer                                                        |
// | Preload -> settle -> run -> dump sequencer for top_float2Float.      |
// | Optional run timeout enabled by macro RUN_TIMEOUT_EN.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module run_sequencer #(
   parameter int            AW         = 8,
   parameter int            DW         = 8,
   parameter logic [AW-1:0] DUMP_BASE  = '0,
   parameter int            DUMP_LEN   = 16,
   parameter int            RST_CYCLES = 2,
   parameter logic [15:0]   TIMEOUT    = 16'd4096
) (
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic         start,
   run_sequencer_if.master   bus,
   output logic              core_reset,
   input  wire logic         core_done,
   output logic              busy,
   output logic              finished,
   output logic              timed_out,
   output logic [15:0]       cycle_count
);
   localparam int c_idx_w = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
   localparam int c_set_w = $clog2(RST_CYCLES + 1);
   localparam logic [c_idx_w-1:0] c_last_idx   = c_idx_w'(DUMP_LEN - 1);
   localparam logic [c_set_w-1:0] c_settle_end = c_set_w'(RST_CYCLES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      DUMP_RD   = 3'd4,
      DUMP_WAIT = 3'd5,
      DUMP_OUT  = 3'd6,
      DONE      = 3'd7
   } state_t;

   state_t              r_state, w_next;
   logic                r_mem_we;
   logic [AW-1:0]       r_mem_addr;
   logic [DW-1:0]       r_mem_wdata;
   logic                r_out_valid;
   logic [AW-1:0]       r_out_addr;
   logic [DW-1:0]       r_out_data;
   logic [15:0]         r_cycle_count;
   logic [c_set_w-1:0]  r_settle;
   logic [c_idx_w-1:0]  r_idx;
   logic                r_core_reset;
   logic                w_accept;
   logic                w_start_ok;
   logic                w_timeout;
   logic [15:0]         w_count_inc;
   logic [c_idx_w-1:0]  w_idx_nxt;
   logic [AW-1:0]       w_rd_addr;

   assign w_accept    = bus.in_valid && (r_state == LOAD);
   assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_count_inc = (r_cycle_count == 16'hFFFF) ? r_cycle_count : r_cycle_count + 16'd1;
   assign w_idx_nxt   = (r_state == RUN) ? '0 : r_idx + 1'b1;
   assign w_rd_addr   = DUMP_BASE + AW'(w_idx_nxt);

`ifdef RUN_TIMEOUT_EN
   logic r_timed_out;
   assign w_timeout = (w_count_inc >= TIMEOUT);
   assign timed_out = r_timed_out;

   always_ff @(posedge clk) begin
      if (reset)
         r_timed_out <= 1'b0;
      else if (w_start_ok)
         r_timed_out <= 1'b0;
      else if ((r_state == RUN) && !core_done && w_timeout)
         r_timed_out <= 1'b1;
   end
`else
   // No timeout in this build; TIMEOUT is still referenced so the parameter list is identical.
   assign w_timeout = 1'b0 && (TIMEOUT != 16'd0);
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: if (start) w_next = LOAD;
         LOAD:       if (w_accept && bus.in_last) w_next = SETTLE;
         SETTLE:     if (r_settle == c_settle_end) w_next = RUN;
         RUN:        if (core_done || w_timeout) w_next = DUMP_RD;
         DUMP_RD:    w_next = DUMP_WAIT;
         DUMP_WAIT:  w_next = DUMP_OUT;
         DUMP_OUT:   if (bus.out_ready) w_next = (r_idx == c_last_idx) ? DONE : DUMP_RD;
         default:    w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_out_valid   <= 1'b0;
         r_out_addr    <= '0;
         r_out_data    <= '0;
         r_cycle_count <= 16'd0;
         r_settle      <= '0;
         r_idx         <= '0;
         r_core_reset  <= 1'b1;
      end else begin
         r_mem_we     <= w_accept;
         r_core_reset <= (w_next != RUN);
         if (w_accept) begin
            r_mem_addr  <= bus.in_addr;
            r_mem_wdata <= bus.in_data;
         end else if (w_next == DUMP_RD) begin
            r_mem_addr  <= w_rd_addr;
         end
         // Settle count starts in the strobe cycle of the final preload write.
         r_settle <= (r_state == SETTLE) ? r_settle + 1'b1 : '0;
         if (w_start_ok)
            r_cycle_count <= 16'd0;
         else if (r_state == RUN)
            r_cycle_count <= w_count_inc;
         if (r_state == RUN)
            r_idx <= '0;
         else if ((r_state == DUMP_OUT) && bus.out_ready)
            r_idx <= w_idx_nxt;
         if (r_state == DUMP_WAIT) begin
            r_out_valid <= 1'b1;
            r_out_addr  <= r_mem_addr;
            r_out_data  <= bus.mem_rdata;
         end else if ((r_state == DUMP_OUT) && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = (r_state == LOAD);
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.out_valid = r_out_valid;
   assign bus.out_addr  = r_out_addr;
   assign bus.out_data  = r_out_data;
   assign core_reset    = r_core_reset;
   assign busy          = (r_state != IDLE) && (r_state != DONE);
   assign finished      = (r_state == DONE);
   assign cycle_count   = r_cycle_count;
endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_run_sequencer                                                     |
// | Self-checking bench: directed table, corner sequences, random runs.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_run_sequencer;
   localparam int         AW         = 8;
   localparam int         DW         = 8;
   localparam int         DUMP_LEN   = 4;
   localparam int         RST_CYCLES = 2;
   localparam int         TO         = 100;
   localparam logic [7:0] DUMP_BASE  = 8'hFE;
`ifdef RUN_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, start, mem_clear;
   logic        core_reset, core_done, busy, finished, timed_out;
   logic [15:0] cycle_count;
   int          errors = 0;
   int          checks = 0;
   int          done_after = 0;
   int          core_k = 0;
   logic [7:0]  mem [256];
   logic [7:0]  exp_mem [256];

   typedef struct {
      logic       v;
      logic [7:0] a;
      logic [7:0] d;
      logic       l;
      logic       e_rdy;
      logic       e_we;
      logic [7:0] e_a;
      logic [7:0] e_d;
      logic       e_cr;
   } vec_t;
   vec_t tbl [6];

   run_sequencer_if #(.AW(AW), .DW(DW)) bus ();

   run_sequencer #(
      .AW(AW), .DW(DW), .DUMP_BASE(DUMP_BASE), .DUMP_LEN(DUMP_LEN),
      .RST_CYCLES(RST_CYCLES), .TIMEOUT(16'(TO))
   ) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus.master),
      .core_reset(core_reset), .core_done(core_done), .busy(busy),
      .finished(finished), .timed_out(timed_out), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int i);
      return 8'(i * 37 + 11);
   endfunction

   // Synchronous-read data memory
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   // Core model: done after done_after cycles out of reset (0 = never)
   always @(posedge clk) core_k <= core_reset ? 0 : core_k + 1;
   assign core_done = !core_reset && (done_after != 0) && (core_k >= done_after - 1);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_start(input int da);
      done_after = da;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", 32'(busy), 1);
      chk("start_in_ready", 32'(bus.in_ready), 1);
      chk("start_finished", 32'(finished), 0);
      chk("start_count", 32'(cycle_count), 0);
      chk("start_timed_out", 32'(timed_out), 0);
      chk("start_core_reset", 32'(core_reset), 1);
   endtask

   task automatic do_load(input int n, input bit gaps);
      logic [7:0] a, d;
      for (int w = 0; w < n; w++) begin
         while (gaps && ($urandom_range(0, 2) == 0)) begin
            bus.in_valid = 1'b0;
            tick();
            chk("gap_we", 32'(bus.mem_we), 0);
            chk("gap_ready", 32'(bus.in_ready), 1);
         end
         a = ($urandom_range(0, 2) == 0) ? DUMP_BASE + 8'($urandom_range(0, 3))
                                         : 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         bus.in_valid = 1'b1;
         bus.in_addr  = a;
         bus.in_data  = d;
         bus.in_last  = (w == n - 1);
         tick();
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
         exp_mem[a] = d;
         chk("load_we", 32'(bus.mem_we), 1);
         chk("load_addr", 32'(bus.mem_addr), 32'(a));
         chk("load_data", 32'(bus.mem_wdata), 32'(d));
      end
      chk("load_ready_drop", 32'(bus.in_ready), 0);
   endtask

   task automatic do_settle();
      int n = 0;
      while (core_reset && n < 20) begin
         tick();
         n++;
      end
      chk("settle_len", 32'(n), 32'(RST_CYCLES + 1));
   endtask

   task automatic do_run_phase(input int da);
      int n = 0;
      bit saw_we = 0;
      int exp_len = (da == 0 || (TO_EN && da > TO)) ? TO : da;
      bit exp_to  = TO_EN && (da == 0 || da > TO);
      while (!core_reset && n < exp_len + 10) begin
         start = 1'($urandom_range(0, 1));
         tick();
         n++;
         if (bus.mem_we) saw_we = 1;
      end
      start = 1'b0;
      chk("run_len", 32'(n), 32'(exp_len));
      chk("run_count", 32'(cycle_count), 32'(exp_len));
      chk("run_timed_out", 32'(timed_out), 32'(exp_to));
      chk("run_no_write", 32'(saw_we), 0);
      chk("dump_busy", 32'(busy), 1);
      chk("dump_entry_valid", 32'(bus.out_valid), 0);
   endtask

   task automatic do_dump(input int stall_word, input int stall_len, input bit rand_stall);
      logic [7:0] a;
      int n, s;
      int cnt = 32'(cycle_count);
      for (int w = 0; w < DUMP_LEN; w++) begin
         n = 0;
         while (!bus.out_valid && n < 10) begin
            tick();
            n++;
         end
         a = DUMP_BASE + 8'(w);
         chk("dump_latency", 32'(n), 2);
         chk("dump_addr", 32'(bus.out_addr), 32'(a));
         chk("dump_data", 32'(bus.out_data), 32'(exp_mem[a]));
         s = (w == stall_word) ? stall_len : (rand_stall ? $urandom_range(0, 3) : 0);
         for (int k = 0; k < s; k++) begin
            tick();
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_addr", 32'(bus.out_addr), 32'(a));
            chk("hold_data", 32'(bus.out_data), 32'(exp_mem[a]));
         end
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
         chk("xfer_valid_drop", 32'(bus.out_valid), 0);
      end
      chk("done_finished", 32'(finished), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_core_reset", 32'(core_reset), 1);
      chk("done_count_kept", 32'(cycle_count), 32'(cnt));
   endtask

   task automatic check_after_reset();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_core_reset", 32'(core_reset), 1);
      chk("rst_count", 32'(cycle_count), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_finished", 32'(finished), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; start = 1'b0; mem_clear = 1'b1;
      bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
      bus.in_last = 1'b0; bus.out_ready = 1'b0;
      for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
      repeat (3) tick();
      check_after_reset();
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
      chk("rst_out_addr", 32'(bus.out_addr), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_timed_out", 32'(timed_out), 0);
      reset = 1'b0; mem_clear = 1'b0;
      tick();

      // Directed preload of three back-to-back words, then settle into RUN
      tbl[0] = '{1'b1, 8'h10, 8'hAA, 1'b0, 1'b1, 1'b1, 8'h10, 8'hAA, 1'b1};
      tbl[1] = '{1'b1, 8'h11, 8'hBB, 1'b0, 1'b1, 1'b1, 8'h11, 8'hBB, 1'b1};
      tbl[2] = '{1'b1, 8'h12, 8'hCC, 1'b1, 1'b0, 1'b1, 8'h12, 8'hCC, 1'b1};
      tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
      tbl[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
      tbl[5] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
      do_start(37);
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = tbl[i].v;
         bus.in_addr  = tbl[i].a;
         bus.in_data  = tbl[i].d;
         bus.in_last  = tbl[i].l;
         tick();
         if (tbl[i].v) exp_mem[tbl[i].a] = tbl[i].d;
         chk("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[i].e_rdy));
         chk("tbl_mem_we", 32'(bus.mem_we), 32'(tbl[i].e_we));
         if (tbl[i].e_we) begin
            chk("tbl_mem_addr", 32'(bus.mem_addr), 32'(tbl[i].e_a));
            chk("tbl_mem_wdata", 32'(bus.mem_wdata), 32'(tbl[i].e_d));
         end
         chk("tbl_core_reset", 32'(core_reset), 32'(tbl[i].e_cr));
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      do_run_phase(37);
      do_dump(1, 5, 1'b0);

      // Random runs, each started from DONE
      for (int r = 0; r < 12; r++) begin
         do_start($urandom_range(1, 50));
         do_load($urandom_range(1, 6), 1'b1);
         do_settle();
         do_run_phase(done_after);
         do_dump(-1, 0, 1'b1);
      end

      // Reset while the core is running
      do_start(0);
      do_load(2, 1'b0);
      do_settle();
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_after_reset();

      // Reset while a dump word is being offered
      do_start(3);
      do_load(1, 1'b0);
      do_settle();
      do_run_phase(3);
      tick(); tick();
      chk("pre_reset_valid", 32'(bus.out_valid), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_after_reset();

`ifdef RUN_TIMEOUT_EN
      do_start(0);
      do_load(2, 1'b0);
      do_settle();
      do_run_phase(0);
      do_dump(-1, 0, 1'b0);
      do_start(TO);
      do_load(2, 1'b0);
      do_settle();
      do_run_phase(TO);
      do_dump(-1, 0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
